// File: rtl/id_imm_stage.sv
// Immediate/field decode stage: decodes each MIPS word on acceptance and holds the
// result in a two-entry in-order buffer (head + skid) with a registered in_ready.
module id_imm_stage #(
    parameter int unsigned BR_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [5:0]  out_opcode,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [5:0]  out_funct,
    output logic [1:0]  out_imm_kind,
    output logic [1:0]  dbg_state
);

    // Handshake: a word moves in when in_valid && in_ready, and a decoded entry
    // moves out when out_valid && out_ready; flush discards both in that cycle.

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [1:0]  kind;
    } dec_t;

    localparam logic [1:0] K_SEXT = 2'd0;
    localparam logic [1:0] K_ZEXT = 2'd1;
    localparam logic [1:0] K_LUI  = 2'd2;
    localparam logic [1:0] K_NONE = 2'd3;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t        d;
        logic [31:0] sext;
        sext     = {{16{instr[15]}}, instr[15:0]};
        d.opcode = instr[31:26];
        d.rs     = instr[25:21];
        d.rt     = instr[20:16];
        d.rd     = instr[15:11];
        d.funct  = instr[5:0];
        d.imm    = sext;
        d.kind   = K_SEXT;
        case (instr[31:26])
            6'h0C, 6'h0D, 6'h0E: begin
                d.imm  = {16'h0000, instr[15:0]};
                d.kind = K_ZEXT;
            end
            6'h0F: begin
                d.imm  = {instr[15:0], 16'h0000};
                d.kind = K_LUI;
            end
            6'h04, 6'h05: begin
                d.imm  = (BR_SHIFT != 0) ? {sext[29:0], 2'b00} : sext;
                d.kind = K_SEXT;
            end
            6'h02, 6'h03: begin
                d.imm  = {4'h0, instr[25:0], 2'b00};
                d.kind = K_NONE;
            end
            6'h00: begin
                d.imm  = 32'h0000_0000;
                d.kind = K_NONE;
            end
            default: begin
                d.imm  = sext;
                d.kind = K_SEXT;
            end
        endcase
        return d;
    endfunction

    occ_t r_state;
    occ_t w_state_next;
    logic r_in_ready;
    dec_t r_head;
    dec_t r_skid;
    dec_t w_dec;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_head;
    logic w_head_from_skid;
    logic w_load_skid;

    assign w_dec      = decode(in_instr);
    // Reset masks in_ready combinationally so no word is taken while rst is high.
    assign in_ready   = r_in_ready && !rst;
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_head      = 1'b0;
        w_head_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_next = S_ONE;
                        w_load_head  = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_head = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_next = S_TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_next = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_out_xfer) begin
                        w_state_next     = S_ONE;
                        w_head_from_skid = 1'b1;
                    end
                end
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != S_TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= w_dec;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign out_imm      = r_head.imm;
    assign out_opcode   = r_head.opcode;
    assign out_rs       = r_head.rs;
    assign out_rt       = r_head.rt;
    assign out_rd       = r_head.rd;
    assign out_funct    = r_head.funct;
    assign out_imm_kind = r_head.kind;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_id_imm_stage.sv
// Bench for id_imm_stage: decode vector table streamed back-to-back, then
// backpressure, flush and mid-operation reset sequences.
module tb_id_imm_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic        in_ready, out_valid;
    logic [31:0] out_imm;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [1:0]  out_imm_kind, dbg_state;
    logic        ns_in_ready, ns_out_valid;
    logic [31:0] ns_out_imm;
    logic [5:0]  ns_out_opcode, ns_out_funct;
    logic [4:0]  ns_out_rs, ns_out_rt, ns_out_rd;
    logic [1:0]  ns_out_imm_kind, ns_dbg_state;

    always #5 clk = ~clk;

    id_imm_stage #(.BR_SHIFT(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_funct(out_funct), .out_imm_kind(out_imm_kind),
        .dbg_state(dbg_state)
    );

    id_imm_stage #(.BR_SHIFT(0)) dut_ns (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ns_in_ready),
        .in_instr(in_instr), .out_valid(ns_out_valid), .out_ready(out_ready),
        .out_imm(ns_out_imm), .out_opcode(ns_out_opcode), .out_rs(ns_out_rs),
        .out_rt(ns_out_rt), .out_rd(ns_out_rd), .out_funct(ns_out_funct),
        .out_imm_kind(ns_out_imm_kind), .dbg_state(ns_dbg_state)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] imm_ns;
        logic [1:0]  kind;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with scoreboard: pops on output transfer, pushes exp_in on input transfer.
    task automatic mon_cycle(input logic [31:0] exp_in, output bit took_in);
        @(negedge clk);
        took_in = 1'b0;
        if (!flush && !rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_spurious: got %0h expected no output", out_imm);
                end else begin
                    check("sb_order", out_imm, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(exp_in);
                took_in = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit took;
        vecs[0]  = '{32'h2108C7EA, 32'hFFFFC7EA, 32'hFFFFC7EA, 2'd0, 6'h08, 5'd8,  5'd8,  5'd24, 6'h2A};
        vecs[1]  = '{32'h3508C7EA, 32'h0000C7EA, 32'h0000C7EA, 2'd1, 6'h0D, 5'd8,  5'd8,  5'd24, 6'h2A};
        vecs[2]  = '{32'h3C08C7EA, 32'hC7EA0000, 32'hC7EA0000, 2'd2, 6'h0F, 5'd0,  5'd8,  5'd24, 6'h2A};
        vecs[3]  = '{32'h1108FFFF, 32'hFFFFFFFC, 32'hFFFFFFFF, 2'd0, 6'h04, 5'd8,  5'd8,  5'd31, 6'h3F};
        vecs[4]  = '{32'h08000010, 32'h00000040, 32'h00000040, 2'd3, 6'h02, 5'd0,  5'd0,  5'd0,  6'h10};
        vecs[5]  = '{32'h014B4820, 32'h00000000, 32'h00000000, 2'd3, 6'h00, 5'd10, 5'd11, 5'd9,  6'h20};
        vecs[6]  = '{32'h3128FFFF, 32'h0000FFFF, 32'h0000FFFF, 2'd1, 6'h0C, 5'd9,  5'd8,  5'd31, 6'h3F};
        vecs[7]  = '{32'h15090004, 32'h00000010, 32'h00000004, 2'd0, 6'h05, 5'd8,  5'd9,  5'd0,  6'h04};
        vecs[8]  = '{32'h8D098000, 32'hFFFF8000, 32'hFFFF8000, 2'd0, 6'h23, 5'd8,  5'd9,  5'd16, 6'h00};
        vecs[9]  = '{32'h0FFFFFFF, 32'h0FFFFFFC, 32'h0FFFFFFC, 2'd3, 6'h03, 5'd31, 5'd31, 5'd31, 6'h3F};
        vecs[10] = '{32'h39087FFF, 32'h00007FFF, 32'h00007FFF, 2'd1, 6'h0E, 5'd8,  5'd8,  5'd15, 6'h3F};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imm", out_imm, 32'h0);
        check("rst_fields", {out_opcode, out_rs, out_rt, out_rd, out_funct, out_imm_kind}, 32'h0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", 32'(in_ready), 32'd1);

        // Streamed decode table, one result per cycle.
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            check($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d_imm_ns", i), ns_out_imm, vecs[i].imm_ns);
            check($sformatf("v%0d_kind", i), 32'(out_imm_kind), 32'(vecs[i].kind));
            check($sformatf("v%0d_opcode", i), 32'(out_opcode), 32'(vecs[i].opcode));
            check($sformatf("v%0d_rs", i), 32'(out_rs), 32'(vecs[i].rs));
            check($sformatf("v%0d_rt", i), 32'(out_rt), 32'(vecs[i].rt));
            check($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d_funct", i), 32'(out_funct), 32'(vecs[i].funct));
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stream_drained", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Backpressure: A and B fill the buffer, C waits.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h21080001; mon_cycle(32'h1, took);
        check("bp_accept_a", 32'(took), 32'd1);
        in_instr = 32'h21080002; mon_cycle(32'h2, took);
        check("bp_accept_b", 32'(took), 32'd1);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        in_instr = 32'h21080003;
        for (int k = 0; k < 3; k++) begin
            mon_cycle(32'h3, took);
            check("bp_hold_c", 32'(took), 32'd0);
            check("bp_in_ready_held", 32'(in_ready), 32'd0);
            check("bp_head_stable", out_imm, 32'h1);
            check("bp_state_two", 32'(dbg_state), 32'd2);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() == 0 && !in_valid) break;
            mon_cycle(32'h3, took);
            if (took) in_valid = 1'b0;
        end
        check("bp_out_count", 32'(n_out), 32'd3);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("bp_idle", 32'(out_valid), 32'd0);

        // Flush while full, with a word offered in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h21080AAA; mon_cycle(32'hAAA, took);
        in_instr = 32'h21080BBB; mon_cycle(32'hBBB, took);
        check("fl_state_two", 32'(dbg_state), 32'd2);
        flush = 1'b1; out_ready = 1'b1; in_instr = 32'h21080DDD;
        mon_cycle(32'hDDD, took);
        exp_q.delete();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            mon_cycle(32'h0, took);
            check("fl_no_ghost", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1; in_instr = 32'h21080EEE;
        mon_cycle(32'hEEE, took);
        in_valid = 1'b0;
        check("fl_next_valid", 32'(out_valid), 32'd1);
        check("fl_next_imm", out_imm, 32'hEEE);
        mon_cycle(32'h0, took);
        check("fl_next_drained", 32'(exp_q.size()), 32'd0);

        // Reset while full.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h21080111; mon_cycle(32'h111, took);
        in_instr = 32'h21080222; mon_cycle(32'h222, took);
        check("rm_state_two", 32'(dbg_state), 32'd2);
        rst = 1'b1; out_ready = 1'b1; in_instr = 32'h21080333;
        #1;
        check("rm_in_ready_now", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        exp_q.delete();
        check("rm_out_valid", 32'(out_valid), 32'd0);
        check("rm_out_imm", out_imm, 32'h0);
        check("rm_in_ready", 32'(in_ready), 32'd0);
        check("rm_opcode", 32'(out_opcode), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rm_release_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_instr = 32'h3C0812AB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rm_first_valid", 32'(out_valid), 32'd1);
        check("rm_first_imm", out_imm, 32'h12AB0000);
        check("rm_first_kind", 32'(out_imm_kind), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
